// File: rtl/ram_mmio_bridge.sv
`default_nettype none
// ============================================================================
// Module   : ram_mmio_bridge
// Brief    : 32-bit MMIO bus to per-channel wide-line BRAM bridge with
//            write staging and a single-line read cache.
// Revision : 1.0 - initial release
// ============================================================================
module ram_mmio_bridge #(
    parameter int V_WIDTH = 1408,
    parameter int BUS_W   = 32,
    parameter int ADDR_W  = 8,
    parameter int N_CH    = 2,
    parameter int RD_LAT  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    bus_valid,
    output logic                    bus_ready,
    input  logic                    bus_we,
    input  logic [31:0]             bus_addr,
    input  logic [BUS_W-1:0]        bus_wdata,
    output logic                    bus_rvalid,
    output logic [BUS_W-1:0]        bus_rdata,
    output logic                    bus_err,
    output logic [N_CH*ADDR_W-1:0]  ch_x_addr,
    output logic [N_CH*V_WIDTH-1:0] ch_x_data,
    output logic [N_CH-1:0]         ch_x_we,
    output logic [N_CH*ADDR_W-1:0]  ch_y_addr,
    input  logic [N_CH*V_WIDTH-1:0] ch_y_data,
    input  logic [N_CH-1:0]         ch_y_inval
);

    localparam int c_WPL  = V_WIDTH / BUS_W;
    localparam int c_CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [1:0] {IDLE, COMMIT, RD_WAIT, RD_RESP} state_t;

    state_t               r_state;
    logic                 r_ready, r_rvalid, r_err;
    logic [BUS_W-1:0]     r_rdata;
    logic [N_CH-1:0]      r_x_we;
    logic [ADDR_W-1:0]    r_xaddr [N_CH];
    logic [V_WIDTH-1:0]   r_xdata [N_CH];
    logic [ADDR_W-1:0]    r_yaddr [N_CH];
    logic [V_WIDTH-1:0]   r_stage [N_CH];
    logic [V_WIDTH-1:0]   r_cache;
    logic                 r_cval;
    logic [c_CH_W-1:0]    r_tch, r_rch;
    logic [ADDR_W-1:0]    r_tline, r_rline;
    logic [5:0]           r_rk;
    logic [2:0]           r_cnt;

    logic [5:0]           w_k;
    logic [ADDR_W-1:0]    w_line;
    logic [3:0]           w_ch;
    logic [c_CH_W-1:0]    w_chi;
    logic                 w_err, w_accept, w_hit;
    logic [V_WIDTH-1:0]   w_yline [N_CH];
    logic [V_WIDTH-1:0]   w_wline, w_cap;
    logic [BUS_W-1:0]     w_cword, w_yword;
    logic                 w_unused;

    assign w_k      = bus_addr[7:2];
    assign w_line   = bus_addr[ADDR_W+7:8];
    assign w_ch     = bus_addr[ADDR_W+11:ADDR_W+8];
    assign w_chi    = w_ch[c_CH_W-1:0];
    assign w_err    = (32'(w_k) >= c_WPL) || (32'(w_ch) >= N_CH);
    assign w_accept = bus_valid && r_ready;
    assign w_hit    = r_cval && (r_tch == w_chi) && (r_tline == w_line);
    assign w_unused = &{1'b0, bus_addr[31:ADDR_W+12], bus_addr[1:0]};

    generate
        for (genvar g = 0; g < N_CH; g++) begin : g_ch
            assign w_yline[g]                       = ch_y_data[g*V_WIDTH +: V_WIDTH];
            assign ch_x_addr[g*ADDR_W +: ADDR_W]    = r_xaddr[g];
            assign ch_x_data[g*V_WIDTH +: V_WIDTH]  = r_xdata[g];
            assign ch_y_addr[g*ADDR_W +: ADDR_W]    = r_yaddr[g];
        end
    endgenerate

    // Word muxes use constant slices so no wide variable part-selects are built.
    always_comb begin
        w_wline = r_stage[w_chi];
        w_cword = '0;
        w_cap   = w_yline[r_rch];
        w_yword = '0;
        for (int w = 0; w < c_WPL; w++) begin
            if (w_k == 6'(w)) begin
                w_wline[w*BUS_W +: BUS_W] = bus_wdata;
                w_cword = r_cache[w*BUS_W +: BUS_W];
            end
            if (r_rk == 6'(w)) begin
                w_yword = w_cap[w*BUS_W +: BUS_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_ready  <= 1'b0;
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
            r_x_we   <= '0;
            r_cache  <= '0;
            r_cval   <= 1'b0;
            r_tch    <= '0;
            r_tline  <= '0;
            r_rch    <= '0;
            r_rline  <= '0;
            r_rk     <= '0;
            r_cnt    <= '0;
            for (int i = 0; i < N_CH; i++) begin
                r_xaddr[i] <= '0;
                r_xdata[i] <= '0;
                r_yaddr[i] <= '0;
                r_stage[i] <= '0;
            end
        end else begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_x_we   <= '0;
            if (r_cval && ch_y_inval[r_tch]) begin
                r_cval <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        if (w_err) begin
                            r_err <= 1'b1;
                            if (!bus_we) begin
                                r_rvalid <= 1'b1;
                                r_rdata  <= '0;
                            end
                        end else if (bus_we) begin
                            r_stage[w_chi] <= w_wline;
                            if (32'(w_k) == c_WPL - 1) begin
                                r_x_we[w_chi]  <= 1'b1;
                                r_xaddr[w_chi] <= w_line;
                                r_xdata[w_chi] <= w_wline;
                                r_ready        <= 1'b0;
                                r_state        <= COMMIT;
                            end
                        end else if (w_hit) begin
                            r_rvalid <= 1'b1;
                            r_rdata  <= w_cword;
                        end else begin
                            r_yaddr[w_chi] <= w_line;
                            r_rch          <= w_chi;
                            r_rline        <= w_line;
                            r_rk           <= w_k;
                            r_cnt          <= 3'd1;
                            r_ready        <= 1'b0;
                            r_state        <= RD_WAIT;
                        end
                    end
                end
                COMMIT: begin
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                RD_WAIT: begin
                    // Capture is ordered after the invalidate so it wins on a tie.
                    if (r_cnt == 3'(RD_LAT)) begin
                        r_cache  <= w_cap;
                        r_cval   <= 1'b1;
                        r_tch    <= r_rch;
                        r_tline  <= r_rline;
                        r_rvalid <= 1'b1;
                        r_rdata  <= w_yword;
                        r_state  <= RD_RESP;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                RD_RESP: begin
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_ready <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus_ready  = r_ready;
    assign bus_rvalid = r_rvalid;
    assign bus_rdata  = r_rdata;
    assign bus_err    = r_err;
    assign ch_x_we    = r_x_we;

endmodule
`default_nettype wire

// File: tb/tb_ram_mmio_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_mmio_bridge
// Brief    : Randomised bench for ram_mmio_bridge against a line-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_mmio_bridge;

    localparam int VW  = 1408;
    localparam int BW  = 32;
    localparam int AW  = 8;
    localparam int NC  = 2;
    localparam int RL  = 2;
    localparam int WPL = VW / BW;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             bus_valid = 1'b0, bus_we = 1'b0;
    logic [31:0]      bus_addr = '0;
    logic [BW-1:0]    bus_wdata = '0;
    logic             bus_ready, bus_rvalid, bus_err;
    logic [BW-1:0]    bus_rdata;
    logic [NC*AW-1:0] ch_x_addr, ch_y_addr;
    logic [NC*VW-1:0] ch_x_data, ch_y_data;
    logic [NC-1:0]    ch_x_we;
    logic [NC-1:0]    ch_y_inval = '0;

    always #5 clk = ~clk;

    ram_mmio_bridge #(.V_WIDTH(VW), .BUS_W(BW), .ADDR_W(AW), .N_CH(NC), .RD_LAT(RL)) dut (
        .clk(clk), .rst_n(rst_n), .bus_valid(bus_valid), .bus_ready(bus_ready),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_err(bus_err),
        .ch_x_addr(ch_x_addr), .ch_x_data(ch_x_data), .ch_x_we(ch_x_we),
        .ch_y_addr(ch_y_addr), .ch_y_data(ch_y_data), .ch_y_inval(ch_y_inval)
    );

    // Output BRAM: address registered once, so data for an address is sampled RL cycles later.
    logic [VW-1:0] mem [NC][256];
    logic [AW-1:0] yad [NC];
    always @(posedge clk) for (int c = 0; c < NC; c++) yad[c] <= ch_y_addr[c*AW +: AW];
    for (genvar g = 0; g < NC; g++) begin : g_bram
        assign ch_y_data[g*VW +: VW] = mem[g][yad[g]];
    end

    // Reference model: staging lines and a one-line cache with tag.
    logic [VW-1:0] m_stage [NC];
    logic [VW-1:0] m_cache;
    bit            m_cval;
    int            m_tch, m_tline;

    int n_cmp = 0, n_bad = 0;
    int we_cnt [NC];
    int rv_cnt = 0;

    initial for (int c = 0; c < NC; c++) we_cnt[c] = 0;
    always @(negedge clk) begin
        for (int c = 0; c < NC; c++) if (ch_x_we[c] === 1'b1) we_cnt[c]++;
        if (bus_rvalid === 1'b1) rv_cnt++;
    end

    function automatic logic [31:0] mk_addr(input int ch, input int line, input int k);
        return 32'((ch << (AW + 8)) | (line << 8) | (k << 2));
    endfunction

    task automatic wait_ready();
        int t = 0;
        while (bus_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (t >= 50) begin n_bad++; $display("FAIL ready_timeout: bus_ready=%b after %0d cycles, want 1", bus_ready, t); end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", bus_ready); end
        n_cmp++; if (bus_rvalid !== 1'b0 || bus_err !== 1'b0) begin n_bad++; $display("FAIL rst_rv_err: got %b/%b want 0/0", bus_rvalid, bus_err); end
        n_cmp++; if (bus_rdata !== '0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", bus_rdata); end
        n_cmp++; if (ch_x_we !== '0) begin n_bad++; $display("FAIL rst_x_we: got %b want 0", ch_x_we); end
        n_cmp++; if (ch_x_addr !== '0 || ch_y_addr !== '0) begin n_bad++; $display("FAIL rst_addr: x=%h y=%h want 0", ch_x_addr, ch_y_addr); end
        n_cmp++; if (ch_x_data !== '0) begin n_bad++; $display("FAIL rst_x_data: low=%h want 0", ch_x_data[63:0]); end
        for (int c = 0; c < NC; c++) m_stage[c] = '0;
        m_cval = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++; if (bus_ready !== 1'b0) begin n_bad++; $display("FAIL rel_ready_early: got %b want 0", bus_ready); end
        @(negedge clk);
        n_cmp++; if (bus_ready !== 1'b1) begin n_bad++; $display("FAIL rel_ready: got %b want 1", bus_ready); end
    endtask

    task automatic bus_write(input int ch, input int line, input int k, input logic [31:0] d);
        bit            err;
        logic [NC-1:0] ew;
        wait_ready();
        bus_valid = 1'b1; bus_we = 1'b1; bus_addr = mk_addr(ch, line, k); bus_wdata = d;
        @(posedge clk); #1;
        bus_valid = 1'b0; bus_we = 1'b0;
        err = (k >= WPL) || (ch >= NC);
        if (!err) m_stage[ch][k*BW +: BW] = d;
        ew = '0;
        if (!err && k == WPL - 1) ew[ch] = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus_err !== err || bus_rvalid !== 1'b0) begin n_bad++; $display("FAIL wr_err ch%0d k%0d: err=%b rvalid=%b want %b/0", ch, k, bus_err, bus_rvalid, err); end
        n_cmp++; if (ch_x_we !== ew) begin n_bad++; $display("FAIL wr_we ch%0d k%0d: got %b want %b", ch, k, ch_x_we, ew); end
        if (ew != '0) begin
            n_cmp++; if (ch_x_addr[ch*AW +: AW] !== AW'(line)) begin n_bad++; $display("FAIL commit_addr ch%0d: got %0d want %0d", ch, ch_x_addr[ch*AW +: AW], line); end
            n_cmp++; if (ch_x_data[ch*VW +: VW] !== m_stage[ch]) begin n_bad++; $display("FAIL commit_data ch%0d: got[63:0]=%h want[63:0]=%h", ch, ch_x_data[ch*VW +: 64], m_stage[ch][63:0]); end
        end
    endtask

    task automatic bus_read(input int ch, input int line, input int k, input bit hold_inval);
        bit          err, hit;
        int          exp_lat, lat;
        logic [31:0] exp_d;
        wait_ready();
        bus_valid = 1'b1; bus_we = 1'b0; bus_addr = mk_addr(ch, line, k);
        @(posedge clk); #1;
        bus_valid = 1'b0;
        err = (k >= WPL) || (ch >= NC);
        hit = m_cval && m_tch == ch && m_tline == line;
        if (err) begin
            exp_lat = 1; exp_d = '0;
        end else if (hit) begin
            exp_lat = 1; exp_d = m_cache[k*BW +: BW];
        end else begin
            exp_lat = RL + 1;
            m_cache = mem[ch][line]; m_cval = 1; m_tch = ch; m_tline = line;
            exp_d = m_cache[k*BW +: BW];
        end
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (bus_rvalid === 1'b1) begin lat = n; break; end
        end
        if (hold_inval) ch_y_inval = '0;
        n_cmp++; if (lat != exp_lat) begin n_bad++; $display("FAIL rd_latency ch%0d l%0d k%0d: got %0d want %0d", ch, line, k, lat, exp_lat); end
        n_cmp++; if (bus_rdata !== exp_d) begin n_bad++; $display("FAIL rd_data ch%0d l%0d k%0d: got %h want %h", ch, line, k, bus_rdata, exp_d); end
        n_cmp++; if (bus_err !== err) begin n_bad++; $display("FAIL rd_err ch%0d k%0d: got %b want %b", ch, k, bus_err, err); end
        if (!err && !hit) begin
            n_cmp++; if (ch_y_addr[ch*AW +: AW] !== AW'(line)) begin n_bad++; $display("FAIL rd_yaddr ch%0d: got %0d want %0d", ch, ch_y_addr[ch*AW +: AW], line); end
        end
        @(negedge clk);
        n_cmp++; if (bus_rvalid !== 1'b0 || bus_err !== 1'b0) begin n_bad++; $display("FAIL rd_pulse: rvalid=%b err=%b want 0/0", bus_rvalid, bus_err); end
    endtask

    task automatic pulse_inval(input int c);
        ch_y_inval[c] = 1'b1;
        @(negedge clk);
        ch_y_inval = '0;
        if (m_cval && m_tch == c) m_cval = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        apply_reset();
    endtask

    task automatic test_write_line();
        int c0 = we_cnt[0], c1 = we_cnt[1];
        for (int k = 0; k < WPL; k++) bus_write(1, 5, k, 32'(k));
        repeat (2) @(negedge clk);
        n_cmp++; if (we_cnt[1] - c1 != 1) begin n_bad++; $display("FAIL line_we1_count: got %0d want 1", we_cnt[1] - c1); end
        n_cmp++; if (we_cnt[0] - c0 != 0) begin n_bad++; $display("FAIL line_we0_count: got %0d want 0", we_cnt[0] - c0); end
        n_cmp++; if (ch_x_data[VW + 7*BW +: BW] !== 32'd7 || ch_x_addr[AW +: AW] !== 8'd5) begin n_bad++; $display("FAIL line_hold: w7=%h addr=%0d want 7/5", ch_x_data[VW + 7*BW +: BW], ch_x_addr[AW +: AW]); end
        // Second commit after rewriting one word keeps the other 43 from before.
        bus_write(1, 6, WPL - 1, 32'hCAFE0001);
    endtask

    task automatic test_read_miss_hit();
        mem[0][3][7*BW +: BW] = 32'hDEADBEEF;
        bus_read(0, 3, 7, 0);
        bus_read(0, 3, 8, 0);
    endtask

    task automatic test_inval();
        pulse_inval(1);
        bus_read(0, 3, 9, 0);
        pulse_inval(0);
        mem[0][3][7*BW +: BW] = 32'h12345678;
        bus_read(0, 3, 7, 0);
        ch_y_inval[0] = 1'b1;
        bus_read(0, 4, 2, 1);
        bus_read(0, 4, 5, 0);
    endtask

    task automatic test_errors();
        int c0 = we_cnt[0], c1 = we_cnt[1];
        bus_write(0, 2, 50, $urandom);
        bus_write(2, 2, WPL - 1, $urandom);
        bus_read(0, 1, 50, 0);
        bus_read(2, 4, 5, 0);
        bus_read(0, 4, 6, 0);
        n_cmp++; if (we_cnt[0] != c0 || we_cnt[1] != c1) begin n_bad++; $display("FAIL err_no_commit: got %0d/%0d extra pulses want 0", we_cnt[0] - c0, we_cnt[1] - c1); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            int op = $urandom_range(0, 9);
            int ch = $urandom_range(0, NC - 1);
            int ln = $urandom_range(0, 3);
            int k  = ($urandom_range(0, 3) == 0) ? WPL - 1 : $urandom_range(0, WPL - 1);
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 1) == 1) k = $urandom_range(WPL, 63);
                else ch = NC;
            end
            if (op < 4) bus_write(ch, ln, k, $urandom);
            else if (op < 8) bus_read(ch, ln, k, 0);
            else if (op == 8) pulse_inval($urandom_range(0, NC - 1));
            else mem[$urandom_range(0, NC - 1)][ln][$urandom_range(0, WPL - 1)*BW +: BW] = $urandom;
        end
    endtask

    task automatic test_reset_abort();
        int c0, rv0;
        for (int k = 0; k < WPL - 1; k++) bus_write(0, 9, k, $urandom);
        c0 = we_cnt[0];
        wait_ready();
        bus_valid = 1'b1; bus_we = 1'b1; bus_addr = mk_addr(0, 9, WPL - 1); bus_wdata = $urandom;
        @(posedge clk); #1;
        bus_valid = 1'b0; bus_we = 1'b0;
        apply_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if (we_cnt[0] != c0) begin n_bad++; $display("FAIL abort_commit: got %0d pulses want 0", we_cnt[0] - c0); end
        rv0 = rv_cnt;
        bus_valid = 1'b1; bus_addr = mk_addr(1, 2, 3);
        @(posedge clk); #1;
        bus_valid = 1'b0;
        apply_reset();
        repeat (6) @(negedge clk);
        n_cmp++; if (rv_cnt != rv0) begin n_bad++; $display("FAIL abort_read: got %0d rvalid pulses want 0", rv_cnt - rv0); end
        bus_read(1, 2, 3, 0);
    endtask

    initial begin
        for (int c = 0; c < NC; c++)
            for (int l = 0; l < 256; l++)
                for (int w = 0; w < WPL; w++) mem[c][l][w*BW +: BW] = $urandom;
        test_reset();
        test_write_line();
        test_read_miss_hit();
        test_inval();
        test_errors();
        test_random();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/ram_mmio_bridge.md
RAM_MMIO_BRIDGE -- requirements
Module: ram_mmio_bridge

Interface
REQ-001 SHALL have parameter V_WIDTH, default 1408, meaning vector line width in bits (176 x 8).
REQ-002 SHALL have parameter BUS_W, default 32, meaning bus data width; V_WIDTH SHALL be a multiple of BUS_W; WPL = V_WIDTH/BUS_W (44 at defaults).
REQ-003 SHALL have parameter ADDR_W, default 8, meaning BRAM line-address width.
REQ-004 SHALL have parameter N_CH, default 2, range 1..16, meaning number of functional-unit channels.
REQ-005 SHALL have parameter RD_LAT, default 1, range 1..4, meaning BRAM read latency in cycles.
REQ-006 clk  input  1  sole clock, all state on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 bus_valid  input  1  request strobe.
REQ-009 bus_ready  output  1  request accepted when bus_valid && bus_ready.
REQ-010 bus_we  input  1  1 = write, 0 = read.
REQ-011 bus_addr  input  32  byte address: [7:2] word-in-line, [ADDR_W+7:8] line, [ADDR_W+11:ADDR_W+8] channel.
REQ-012 bus_wdata  input  BUS_W  write data.
REQ-013 bus_rvalid  output  1  one-cycle read-response pulse.
REQ-014 bus_rdata  output  BUS_W  read data, valid with bus_rvalid.
REQ-015 bus_err  output  1  one-cycle pulse, decode error on an accepted request.
REQ-016 ch_x_addr  output  N_CH*ADDR_W  per-channel input-BRAM write address.
REQ-017 ch_x_data  output  N_CH*V_WIDTH  per-channel input-BRAM write line.
REQ-018 ch_x_we  output  N_CH  per-channel write enable.
REQ-019 ch_y_addr  output  N_CH*ADDR_W  per-channel output-BRAM read address.
REQ-020 ch_y_data  input  N_CH*V_WIDTH  per-channel output-BRAM read line.
REQ-021 ch_y_inval  input  N_CH  per-channel pulse, FU has rewritten its output BRAM.

Function
REQ-022 Decode error: word index >= WPL or channel >= N_CH; accepted erroneous write SHALL be dropped; erroneous read SHALL return bus_rdata=0 with bus_rvalid and bus_err in the same cycle, one cycle after accept.
REQ-023 FSM states IDLE, COMMIT, RD_WAIT, RD_RESP; bus_ready SHALL be 1 only in IDLE.
REQ-024 Write, word k < WPL-1: staging[ch] slice [k*BUS_W +: BUS_W] SHALL update on the accept edge; FSM stays IDLE; no ch_x_we.
REQ-025 Write, k = WPL-1: slice SHALL update and FSM SHALL enter COMMIT; in COMMIT, ch_x_we[ch]=1 for exactly one cycle with ch_x_addr[ch]=line and ch_x_data[ch]=full staging line including the last word; then IDLE.
REQ-026 Staging buffers SHALL NOT clear on commit; untouched words retain prior values.
REQ-027 Read, tag hit (cache valid, cache ch/line match): next cycle bus_rvalid=1, bus_rdata=cache slice k; FSM remains IDLE.
REQ-028 Read, miss: FSM enters RD_WAIT, drives ch_y_addr[ch]=line, waits RD_LAT cycles, captures ch_y_data[ch] into the cache and sets the tag, then RD_RESP for one cycle with bus_rvalid=1 and slice k; then IDLE.
REQ-029 Read miss latency from accept edge to bus_rvalid SHALL be RD_LAT+1 cycles; hit latency SHALL be 1 cycle.
REQ-030 Cache valid SHALL clear when ch_y_inval[tag ch] is 1; if this coincides with the capture edge, capture wins and valid SHALL be set.
REQ-031 ch_y_addr SHALL hold its last driven value outside RD_WAIT; ch_x_addr/ch_x_data SHALL hold between commits.
REQ-032 bus_rvalid and bus_err SHALL never assert without a preceding accepted request.

Reset
REQ-033 While rst_n=0: FSM=IDLE, bus_ready=0, bus_rvalid=0, bus_err=0, bus_rdata=0, ch_x_we=0, ch_x_addr=0, ch_x_data=0, ch_y_addr=0, cache valid=0, all staging buffers=0.
REQ-034 bus_ready SHALL rise in the first cycle after rst_n deasserts.
REQ-035 Reset mid-COMMIT or mid-RD_WAIT SHALL abort the operation: no ch_x_we pulse and no bus_rvalid for it.

Verification
REQ-036 Write words 0..43 of ch1, line 5, data = word index -> exactly one ch_x_we[1] pulse, ch_x_addr[1]=5, slice k = k; ch_x_we[0] stays 0.
REQ-037 RD_LAT=2, read ch0 line 3 word 7 with ch_y_data[0] slice 7 = 0xDEADBEEF -> bus_rvalid at accept+3 with 0xDEADBEEF; repeat read word 8 -> bus_rvalid at accept+1 (hit).
REQ-038 After cached read, pulse ch_y_inval[0], change BRAM data, re-read -> miss timing, new data returned.
REQ-039 Access word index 50 or channel 2 (N_CH=2) -> write dropped; read returns 0 with bus_rvalid and bus_err same cycle.
REQ-040 Assert rst_n=0 during COMMIT of line 9 -> no ch_x_we, all outputs 0, bus_ready=1 the cycle after release.
